sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- Synthesizable SPI-mode SD card responder, the card end of the SD command link. Used as an on-chip card model for bring-up and regression of the host command engine.
- Shifts in 48-bit command frames on mosi and returns R1 responses on miso. For CMD17 it also returns a start token and a data block fetched from a backing-store read port.
- Runs one bit per clk, in the host's bit clock domain.

Parameters:
- RESP_DELAY, 1, idle (miso=1) cycles between the frame's last bit and the R1 MSB; legal range 1..8.
- DATA_DELAY, 2, idle cycles between the R1 LSB and the first bit of the 0xFE token; legal range 1..16.
- DATA_BYTES, 4, bytes per CMD17 block.
- NUM_BLOCKS, 1024, number of valid block addresses.

Ports:
- clk  in  1  bit clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select, active low.
- mosi  in  1  host-to-card serial data (host D1).
- miso  out  1  card-to-host serial data (host D0). Forced to 1 combinationally whenever cs_n=1.
- cmd_valid  out  1  one-cycle pulse on the cycle a complete frame is latched.
- cmd_index  out  6  index of the last latched frame.
- cmd_arg  out  32  argument of the last latched frame.
- in_idle  out  1  card idle-state flag.
- rd_req  out  1  one-cycle pulse requesting one data byte.
- rd_block  out  32  block address (the CMD17 argument); stable for the whole data phase.
- rd_byte  out  $clog2(DATA_BYTES)  index of the requested byte.
- rd_data  in  8  requested byte; sampled on the clk edge after rd_req.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - miso=1, in_idle=1.
  - cmd_valid, rd_req and busy = 0.
  - cmd_index, cmd_arg, rd_block, rd_byte = 0.
  - app_cmd flag = 0.
- Frame format, MSB first: 8-bit command byte {0,1,index[5:0]}, then 32-bit argument, then 8-bit CRC byte {crc7, end bit}.
- States: IDLE, RX, NCR, R1, NAC, TOKEN, DATA, CRC (CRC exists only with the optional feature).
- IDLE:
  - miso=1.
  - If cs_n=0 and mosi=0 (the start bit), go to RX with bit count 1.
- RX:
  - Shift mosi every cycle while cs_n=0.
  - After bit 48, pulse cmd_valid, latch cmd_index and cmd_arg, compute R1, and go to NCR.
- R1 bit layout: [7]=0, [6] param, [5] addr_err, [4]=0, [3] crc_err, [2] illegal, [1]=0, [0]=in_idle. The in_idle bit reports the value after the command executes.
- Command decode:
  - Transmission bit (byte0[6]) = 0, or end bit = 0: crc_err=1; the command is not executed.
  - CMD0: in_idle<=1, app_cmd<=0. Response 0x01.
  - CMD55: app_cmd<=1.
  - CMD41 with app_cmd=1: in_idle<=0. Response 0x00.
  - CMD41 without app_cmd: illegal.
  - CMD17 with in_idle=1: illegal, no data phase.
  - CMD17 with arg >= NUM_BLOCKS: addr_err, no data phase.
  - CMD17 otherwise: data phase follows R1.
  - Every other index (including CMD8): illegal, giving 0x05 while idle.
  - app_cmd clears after any command other than CMD55.
- NCR: miso=1 for RESP_DELAY cycles, then R1.
- R1: drive the 8 R1 bits MSB first. Then go to NAC if a data phase follows, else IDLE.
- NAC: miso=1 for DATA_DELAY cycles. rd_req pulses with rd_byte=0 on the final NAC cycle.
- TOKEN: drive 0xFE, MSB first.
- DATA:
  - Drive DATA_BYTES bytes, MSB first.
  - rd_req for byte k+1 pulses on bit 7 of byte k, i.e. one cycle before that byte's MSB; rd_data is loaded into the shifter on the next edge.
  - After the last bit, go to IDLE (or to CRC when the feature is enabled).
- mosi is ignored from NCR through the end of the data phase; no full-duplex command overlap.
- cs_n=1 in any state: next state is IDLE and all partial frame/response/data state is discarded. in_idle and app_cmd keep their current values; no cmd_valid.
- reset_n low mid-operation: immediately return to reset values.

Optional Feature:
- Macro SD_RESP_CRC16_EN.
- When defined: a CRC state follows DATA and drives a 16-bit CRC-16/XMODEM (poly 0x1021, init 0x0000) over the data bytes, MSB first, then returns to IDLE.
- When undefined: no CRC state; DATA goes straight to IDLE.

Test Plan:
- Reset, then CMD0 frame 0x40,0x00000000,0x95 -> cmd_valid pulse; miso=1 for RESP_DELAY cycles; R1=0x01; return to IDLE.
- After CMD0, send CMD17 (0x51, arg 0, 0xFF) -> R1=0x05; no token; rd_req never asserts.
- Send CMD55 (R1=0x01), then CMD41 0x69 (R1=0x00, in_idle=0). Then CMD17 arg 3 with rd_data bytes A5,5A,3C,C3 -> R1=0x00; 2 idle cycles; 0xFE; bytes A5 5A 3C C3; 4 rd_req pulses with rd_block=3 and rd_byte=0..3.
- After CMD55/CMD41, CMD17 arg 1024 -> R1=0x20; no data phase.
- Raise cs_n at frame bit 20 -> miso=1, no cmd_valid. A following complete CMD0 -> R1=0x01.
- With SD_RESP_CRC16_EN and DATA_BYTES=9, CMD17 returning ASCII "123456789" -> 16 CRC bits 0x31C3 follow the data.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes 48-bit command frames, returns R1 and serves CMD17 blocks.
// Optional macro SD_RESP_CRC16_EN appends a CRC-16/XMODEM after each data block.
module sd_spi_responder #(
  parameter  int RESP_DELAY = 1,
  parameter  int DATA_DELAY = 2,
  parameter  int DATA_BYTES = 4,
  parameter  int NUM_BLOCKS = 1024,
  localparam int BW         = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          cmd_valid,
  output logic [5:0]    cmd_index,
  output logic [31:0]   cmd_arg,
  output logic          in_idle,
  output logic          rd_req,
  output logic [31:0]   rd_block,
  output logic [BW-1:0] rd_byte,
  input  logic [7:0]    rd_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_NCR,
    ST_R1,
    ST_NAC,
    ST_TOKEN,
`ifdef SD_RESP_CRC16_EN
    ST_DATA,
    ST_CRC
`else
    ST_DATA
`endif
  } state_t;

  localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_BYTES - 1);

  state_t        r_state;
  logic [5:0]    r_cnt;
  logic [45:0]   r_shift;
  logic [7:0]    r_tx;
  logic [7:0]    r_buf;
  logic          r_data_phase;
  logic [BW-1:0] r_byte_idx;
  logic          r_in_idle;
  logic          r_app_cmd;
  logic          r_cmd_valid;
  logic [5:0]    r_cmd_index;
  logic [31:0]   r_cmd_arg;
  logic          r_rd_req;
  logic [31:0]   r_rd_block;
  logic [BW-1:0] r_rd_byte;

  // Frame bits 2..48; the start bit is implied by having left IDLE.
  logic [46:0]   w_frame;
  logic [7:0]    w_r1;
  logic          w_in_idle_nxt;
  logic          w_app_nxt;
  logic          w_data_go;
  logic          w_tx_bit;

  assign w_frame = {r_shift, mosi};

`ifdef SD_RESP_CRC16_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;

  always_comb begin
    w_crc_nxt = {r_crc[14:0], 1'b0};
    if (r_crc[15] ^ r_tx[7]) w_crc_nxt = w_crc_nxt ^ 16'h1021;
  end
`endif

  // Command decode, evaluated on the cycle the 48th bit arrives.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_r1          = 8'h00;
    w_in_idle_nxt = r_in_idle;
    w_app_nxt     = 1'b0;
    w_data_go     = 1'b0;
    if (!w_frame[46] || !w_frame[0]) begin
      w_r1[3]   = 1'b1;
      w_app_nxt = r_app_cmd;
    end else begin
      case (w_frame[45:40])
        6'd0:  w_in_idle_nxt = 1'b1;
        6'd55: w_app_nxt = 1'b1;
        6'd41: begin
          if (r_app_cmd) w_in_idle_nxt = 1'b0;
          else           w_r1[2] = 1'b1;
        end
        6'd17: begin
          if (r_in_idle)                              w_r1[2] = 1'b1;
          else if (w_frame[39:8] >= 32'(NUM_BLOCKS))  w_r1[5] = 1'b1;
          else                                        w_data_go = 1'b1;
        end
        default: w_r1[2] = 1'b1;
      endcase
    end
    w_r1[0] = w_in_idle_nxt;
  end

  always_comb begin
    w_tx_bit = 1'b1;
    case (r_state)
      ST_R1, ST_TOKEN, ST_DATA: w_tx_bit = r_tx[7];
`ifdef SD_RESP_CRC16_EN
      ST_CRC:                   w_tx_bit = r_crc[15];
`endif
      default:                  w_tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_tx         <= 8'hFF;
      r_buf        <= '0;
      r_data_phase <= 1'b0;
      r_byte_idx   <= '0;
      r_in_idle    <= 1'b1;
      r_app_cmd    <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_index  <= '0;
      r_cmd_arg    <= '0;
      r_rd_req     <= 1'b0;
      r_rd_block   <= '0;
      r_rd_byte    <= '0;
`ifdef SD_RESP_CRC16_EN
      r_crc        <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_cmd_valid <= 1'b0;
      r_rd_req    <= 1'b0;
      if (cs_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!mosi) begin
              r_state <= ST_RX;
              r_cnt   <= 6'd1;
              r_shift <= '0;
            end
          end

          ST_RX: begin
            if (r_cnt == 6'd47) begin
              r_cmd_valid  <= 1'b1;
              r_cmd_index  <= w_frame[45:40];
              r_cmd_arg    <= w_frame[39:8];
              r_in_idle    <= w_in_idle_nxt;
              r_app_cmd    <= w_app_nxt;
              r_tx         <= w_r1;
              r_data_phase <= w_data_go;
              if (w_data_go) r_rd_block <= w_frame[39:8];
              r_cnt        <= 6'(RESP_DELAY - 1);
              r_state      <= ST_NCR;
            end else begin
              r_shift <= w_frame[45:0];
              r_cnt   <= r_cnt + 6'd1;
            end
          end

          ST_NCR: begin
            if (r_cnt == 6'd0) begin
              r_state <= ST_R1;
              r_cnt   <= 6'd7;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end

          ST_R1: begin
            r_tx <= {r_tx[6:0], 1'b1};
            if (r_cnt == 6'd0) begin
              if (r_data_phase) begin
                r_state    <= ST_NAC;
                r_cnt      <= 6'(DATA_DELAY - 1);
                r_byte_idx <= '0;
                // With a one-cycle gap the first byte request coincides with the only NAC cycle.
                if (DATA_DELAY == 1) begin
                  r_rd_req  <= 1'b1;
                  r_rd_byte <= '0;
                end
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end

          ST_NAC: begin
            if (r_cnt == 6'd0) begin
              r_state <= ST_TOKEN;
              r_cnt   <= 6'd7;
              r_tx    <= 8'hFE;
              r_buf   <= rd_data;
            end else begin
              r_cnt <= r_cnt - 6'd1;
              if (r_cnt == 6'd1) begin
                r_rd_req  <= 1'b1;
                r_rd_byte <= '0;
              end
            end
          end

          ST_TOKEN: begin
            if (r_cnt == 6'd0) begin
              r_state <= ST_DATA;
              r_cnt   <= 6'd7;
              r_tx    <= r_buf;
`ifdef SD_RESP_CRC16_EN
              r_crc   <= '0;
`endif
            end else begin
              r_tx  <= {r_tx[6:0], 1'b1};
              r_cnt <= r_cnt - 6'd1;
            end
          end

          ST_DATA: begin
`ifdef SD_RESP_CRC16_EN
            r_crc <= w_crc_nxt;
`endif
            if (r_cnt == 6'd0) begin
              if (r_byte_idx == LAST_BYTE) begin
`ifdef SD_RESP_CRC16_EN
                r_state <= ST_CRC;
                r_cnt   <= 6'd15;
`else
                r_state <= ST_IDLE;
`endif
              end else begin
                r_tx       <= rd_data;
                r_byte_idx <= r_byte_idx + 1'b1;
                r_cnt      <= 6'd7;
              end
            end else begin
              r_tx  <= {r_tx[6:0], 1'b1};
              r_cnt <= r_cnt - 6'd1;
              // Request the next byte so it is sampled as the current byte's last bit leaves.
              if (r_cnt == 6'd1 && r_byte_idx != LAST_BYTE) begin
                r_rd_req  <= 1'b1;
                r_rd_byte <= r_byte_idx + 1'b1;
              end
            end
          end

`ifdef SD_RESP_CRC16_EN
          ST_CRC: begin
            r_crc <= {r_crc[14:0], 1'b0};
            if (r_cnt == 6'd0) r_state <= ST_IDLE;
            else               r_cnt   <= r_cnt - 6'd1;
          end
`endif

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso      = cs_n | w_tx_bit;
  assign cmd_valid = r_cmd_valid;
  assign cmd_index = r_cmd_index;
  assign cmd_arg   = r_cmd_arg;
  assign in_idle   = r_in_idle;
  assign rd_req    = r_rd_req;
  assign rd_block  = r_rd_block;
  assign rd_byte   = r_rd_byte;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: expected miso bits are queued as each frame is sent
// and popped as the card answers; a monitor serves rd_req from a local block image.
module tb_sd_spi_responder;

  localparam int RESP_DELAY = 1;
  localparam int DATA_DELAY = 2;
`ifdef SD_RESP_CRC16_EN
  localparam int NB = 9;
`else
  localparam int NB = 4;
`endif
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic          cmd_valid;
  logic [5:0]    cmd_index;
  logic [31:0]   cmd_arg;
  logic          in_idle;
  logic          rd_req;
  logic [31:0]   rd_block;
  logic [BW-1:0] rd_byte;
  logic [7:0]    rd_data;
  logic          busy;

  sd_spi_responder #(
    .RESP_DELAY (RESP_DELAY),
    .DATA_DELAY (DATA_DELAY),
    .DATA_BYTES (NB),
    .NUM_BLOCKS (1024)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .in_idle   (in_idle),
    .rd_req    (rd_req),
    .rd_block  (rd_block),
    .rd_byte   (rd_byte),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_cv  = 0;
  int          n_req = 0;
  int          exp_byte;
  logic [31:0] exp_block;
  logic [7:0]  tb_mem [NB];
  bit          exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing-store model: answers each request for one cycle only, so a mistimed sample reads 0.
  always @(negedge clk) begin
    if (cmd_valid) n_cv++;
    if (rd_req) begin
      check("rd_block", rd_block, exp_block);
      check("rd_byte", 32'(rd_byte), 32'(exp_byte));
      rd_data = (int'(rd_byte) < NB) ? tb_mem[int'(rd_byte)] : 8'h00;
      exp_byte++;
      n_req++;
    end else begin
      rd_data = 8'h00;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] c0, input logic [31:0] arg,
                          input logic [7:0] crc, input logic [7:0] r1, input bit data);
    logic [47:0] frame;
    logic [15:0] crc16;
    int          cv0;
    int          rq0;
    bit          first;
    bit          b;
    frame     = {c0, arg, crc};
    cv0       = n_cv;
    rq0       = n_req;
    exp_byte  = 0;
    exp_block = arg;
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      mosi = frame[i];
    end
    for (int i = 0; i < RESP_DELAY; i++) exp_q.push_back(1'b1);
    push_byte(r1);
    if (data) begin
      for (int i = 0; i < DATA_DELAY; i++) exp_q.push_back(1'b1);
      push_byte(8'hFE);
      for (int k = 0; k < NB; k++) push_byte(tb_mem[k]);
`ifdef SD_RESP_CRC16_EN
      crc16 = 16'h31C3;
      push_byte(crc16[15:8]);
      push_byte(crc16[7:0]);
`else
      crc16 = 16'h0000;
`endif
    end
    first = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      mosi = 1'b1;
      if (first) begin
        check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd1);
        check({tag, " cmd_index"}, 32'(cmd_index), 32'(c0[5:0]));
        check({tag, " cmd_arg"}, cmd_arg, arg);
        first = 1'b0;
      end
      b = exp_q.pop_front();
      check({tag, " miso"}, 32'(miso), 32'(b));
    end
    @(negedge clk);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " cmd_valid_count"}, 32'(n_cv - cv0), 32'd1);
    check({tag, " rd_req_count"}, 32'(n_req - rq0), data ? 32'(NB) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef SD_RESP_CRC16_EN
    for (int k = 0; k < NB; k++) tb_mem[k] = 8'(8'h31 + k);
`else
    tb_mem[0] = 8'hA5;
    tb_mem[1] = 8'h5A;
    tb_mem[2] = 8'h3C;
    tb_mem[3] = 8'hC3;
`endif
    reset_n   = 1'b0;
    cs_n      = 1'b1;
    mosi      = 1'b1;
    rd_data   = 8'h00;
    exp_byte  = 0;
    exp_block = '0;
    repeat (3) @(negedge clk);
    check("rst miso", 32'(miso), 32'd1);
    check("rst in_idle", 32'(in_idle), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst rd_req", 32'(rd_req), 32'd0);
    check("rst cmd_index", 32'(cmd_index), 32'd0);
    check("rst cmd_arg", cmd_arg, 32'd0);
    check("rst rd_block", rd_block, 32'd0);
    check("rst rd_byte", 32'(rd_byte), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);

    send_cmd("cmd0",        8'h40, 32'd0,     8'h95, 8'h01, 1'b0);
    send_cmd("cmd17_idle",  8'h51, 32'd0,     8'hFF, 8'h05, 1'b0);
    send_cmd("cmd41_noapp", 8'h69, 32'd0,     8'hE5, 8'h05, 1'b0);
    send_cmd("cmd8",        8'h48, 32'h1AA,   8'h87, 8'h05, 1'b0);
    send_cmd("cmd55_a",     8'h77, 32'd0,     8'h65, 8'h01, 1'b0);
    send_cmd("acmd41_a",    8'h69, 32'd0,     8'hE5, 8'h00, 1'b0);
    check("in_idle after acmd41", 32'(in_idle), 32'd0);
    send_cmd("cmd17_blk3",  8'h51, 32'd3,     8'hFF, 8'h00, 1'b1);
    send_cmd("cmd55_b",     8'h77, 32'd0,     8'h65, 8'h00, 1'b0);
    send_cmd("acmd41_b",    8'h69, 32'd0,     8'hE5, 8'h00, 1'b0);
    send_cmd("cmd17_1024",  8'h51, 32'd1024,  8'hFF, 8'h20, 1'b0);
    send_cmd("cmd17_1023",  8'h51, 32'd1023,  8'hFF, 8'h00, 1'b1);
    send_cmd("cmd0_badend", 8'h40, 32'd0,     8'h94, 8'h08, 1'b0);
    check("in_idle after bad frame", 32'(in_idle), 32'd0);
    send_cmd("cmd0_notx",   8'h00, 32'd0,     8'h95, 8'h08, 1'b0);

    // Abort a CMD0 frame after 20 bits by deselecting the card.
    begin
      logic [47:0] fr;
      int          cv0;
      fr  = {8'h40, 32'd0, 8'h95};
      cv0 = n_cv;
      for (int i = 47; i >= 28; i--) begin
        @(negedge clk);
        mosi = fr[i];
      end
      @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b1;
      #1 check("abort miso forced", 32'(miso), 32'd1);
      repeat (3) begin
        @(negedge clk);
        check("abort miso", 32'(miso), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
      end
      cs_n = 1'b0;
      repeat (2) @(negedge clk);
      check("abort no cmd_valid", 32'(n_cv - cv0), 32'd0);
      check("abort in_idle kept", 32'(in_idle), 32'd0);
    end
    send_cmd("cmd0_after_abort", 8'h40, 32'd0, 8'h95, 8'h01, 1'b0);
    check("in_idle after cmd0", 32'(in_idle), 32'd1);

    // Asynchronous reset in the middle of a frame.
    send_cmd("cmd55_c",  8'h77, 32'd0, 8'h65, 8'h01, 1'b0);
    send_cmd("acmd41_c", 8'h69, 32'd0, 8'hE5, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mosi = (i == 0) ? 1'b0 : 1'b1;
    end
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst in_idle", 32'(in_idle), 32'd1);
    check("async rst miso", 32'(miso), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
